// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op encodings, FSM states and small decode helpers.
package md_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_DIV   = 2'b01;
   localparam logic [1:0] MD_MULTU = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DZ
   } md_state_t;

   function automatic logic is_div(input logic [1:0] op);
      return op[0];
   endfunction

   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[1];
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned radix-2 iterative datapath: shift-add multiply
// and restoring divide, one step per enabled edge.
module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   opnd;
   logic               mode;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_nxt;

   // Next accumulator value for one multiply or divide step.
   always_comb begin
      add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      trial   = acc[2*WIDTH-1:WIDTH-1];
      diff    = trial - {1'b0, opnd};
      acc_nxt = acc;
      if (mode) begin
         if (!diff[WIDTH])
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
         else
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

   // Operand capture on load, one iteration per step.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc  <= '0;
         opnd <= '0;
         mode <= 1'b0;
      end else if (load) begin
         mode <= div_mode;
         if (div_mode) begin
            acc  <= {{WIDTH{1'b0}}, a_mag};
            opnd <= b_mag;
         end else begin
            acc  <= {{WIDTH{1'b0}}, b_mag};
            opnd <= a_mag;
         end
      end else if (step) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO with
// a start/busy/done handshake and divide-by-zero flag.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   md_state_t          state;
   logic [CNT_W-1:0]   cnt;
   logic               div_r;
   logic               neg_q;
   logic               neg_r;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               accept;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign a_neg  = is_signed_op(op) & a[WIDTH-1];
   assign b_neg  = is_signed_op(op) & b[WIDTH-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;
   assign accept = (state == IDLE) & start & ~abort;
   assign busy   = (state != IDLE);

   md_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clock    (clock),
      .reset    (reset),
      .load     (accept),
      .step     (state == CALC),
      .div_mode (is_div(op)),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .acc      (acc)
   );

   // Sign-corrected result from the unsigned accumulator.
   always_comb begin
      prod   = neg_q ? -acc : acc;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (div_r) begin
         res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH]
                        : acc[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM with registered HI/LO and done/div_zero pulses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         div_r    <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  div_r <= is_div(op);
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  cnt   <= '0;
                  if (is_div(op) && (b == '0))
                     state <= DZ;
                  else
                     state <= CALC;
               end
            end
            CALC: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST)
                     state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               if (!abort) begin
                  hi   <= res_hi;
                  lo   <= res_lo;
                  done <= 1'b1;
               end
            end
            DZ: begin
               state <= IDLE;
               if (!abort) begin
                  done     <= 1'b1;
                  div_zero <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized scoreboard bench for mult_div_unit against a
// plain-arithmetic reference of MIPS MULT/MULTU/DIV/DIVU.
module tb_mult_div_unit;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           cyc;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           cyc = 0;
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   exp_t         sb[$];

   mult_div_unit #(
      .WIDTH (W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t ref_op(input logic [1:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic [W-1:0] ch,
                                   input logic [W-1:0] cl);
      exp_t        e;
      longint      sx, sy, q, r;
      logic [63:0] pv;
      e.hi  = ch;
      e.lo  = cl;
      e.dz  = 1'b0;
      e.cyc = 0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: begin
            pv   = sx * sy;
            e.hi = pv[63:32];
            e.lo = pv[31:0];
         end
         2'b10: begin
            pv   = {32'b0, x} * {32'b0, y};
            e.hi = pv[63:32];
            e.lo = pv[31:0];
         end
         2'b01: begin
            if (y == '0) begin
               e.dz = 1'b1;
            end else begin
               q    = sx / sy;
               r    = sx % sy;
               pv   = q;
               e.lo = pv[31:0];
               pv   = r;
               e.hi = pv[31:0];
            end
         end
         default: begin
            if (y == '0) begin
               e.dz = 1'b1;
            end else begin
               e.lo = x / y;
               e.hi = x % y;
            end
         end
      endcase
      return e;
   endfunction

   // Monitor: pop and compare on every done pulse.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         if (done) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", 64'(cyc), 64'(e.cyc));
               chk("hi", 64'(hi), 64'(e.hi));
               chk("lo", 64'(lo), 64'(e.lo));
               chk("div_zero", 64'(div_zero), 64'(e.dz));
            end
         end else if (div_zero) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_div_zero: at cycle %0d", cyc);
         end
      end
   end

   // Called right after a falling edge; holds start one cycle.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit push);
      exp_t e;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (push) begin
         e = ref_op(o, x, y, m_hi, m_lo);
         e.cyc = cyc + 1 + (e.dz ? 1 : W + 1);
         sb.push_back(e);
         m_hi = e.hi;
         m_lo = e.lo;
      end
      @(negedge clock);
      start = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (done) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: timeout at cycle %0d", cyc);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;

      repeat (3) @(negedge clock);
      chk("rst_busy", 64'(busy), 64'(1'b0));
      chk("rst_done", 64'(done), 64'(1'b0));
      chk("rst_hi", 64'(hi), 64'(m_hi));
      chk("rst_lo", 64'(lo), 64'(m_lo));
      reset = 1'b1;
      @(negedge clock);

      issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1);
      chk("busy_after_start", 64'(busy), 64'(1'b1));
      wait_done();

      issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      wait_done();
      issue(2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 1);
      wait_done();

      issue(2'b11, 32'h0000_0064, 32'h0, 1);
      wait_done();

      issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      wait_done();
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      wait_done();

      issue(2'b00, 32'd5, 32'd6, 1);
      repeat (8) @(negedge clock);
      start = 1'b1;
      op    = 2'b11;
      a     = 32'd1000;
      b     = 32'd7;
      @(negedge clock);
      start = 1'b0;
      wait_done();
      issue(2'b10, $urandom, $urandom, 1);
      wait_done();

      start = 1'b1;
      abort = 1'b1;
      op    = 2'b00;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_busy", 64'(busy), 64'(1'b0));

      issue(2'b00, $urandom, $urandom, 0);
      repeat (11) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'(1'b0));
      repeat (40) @(negedge clock);
      chk("abort_hi", 64'(hi), 64'(m_hi));
      chk("abort_lo", 64'(lo), 64'(m_lo));

      issue(2'b11, $urandom, 32'd13, 0);
      repeat (14) @(negedge clock);
      reset = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      chk("midrst_busy", 64'(busy), 64'(1'b0));
      chk("midrst_done", 64'(done), 64'(1'b0));
      chk("midrst_hi", 64'(hi), 64'(m_hi));
      chk("midrst_lo", 64'(lo), 64'(m_lo));
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = pick();
         rb = pick();
         issue(ro, ra, rb, 1);
         wait_done();
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clock);
      end

      repeat (5) @(negedge clock);
      chk("scoreboard_empty", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
